// File: rtl/seqmpy_accum.sv
// seqmpy_accum: iterative signed multiplier, radix-4 (two multiplier bits per cycle).
// The operands are converted to sign/magnitude when they are accepted. The
// magnitude of i_a is then consumed two bits per cycle. Each cycle forms a
// 2 x IBW partial product, shifts it and adds it into an unsigned accumulator.
// The sign is applied once, in the FIX cycle.
//
// Ports:
//   i_clk      clock, all state on the rising edge
//   i_reset_n  asynchronous active-low reset
//   i_ce       clock enable; when low every register holds
//   i_start    request; accepted only in IDLE with i_ce high
//   i_a        signed multiplier (IAW bits), captured with i_start
//   i_b        signed multiplicand (IBW bits), captured with i_start
//   o_busy     high while a product is in progress
//   o_done     one enabled-cycle pulse when o_p is updated
//   o_p        signed product (IAW+IBW bits), held until the next o_done
//
// state  | meaning
// S_IDLE | waiting for i_start, o_busy low
// S_RUN  | accumulating digit k = 0..N-1
// S_FIX  | apply sign, load o_p, pulse o_done
module seqmpy_accum #(
    parameter int IAW = 16,
    parameter int IBW = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_ce,
    input  logic               i_start,
    input  logic [IAW-1:0]     i_a,
    input  logic [IBW-1:0]     i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [IAW+IBW-1:0] o_p
);
    localparam int N  = IAW / 2;
    localparam int PW = IAW + IBW;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          state;
    logic [IAW-1:0]  a_sh;     // |a|, shifted right two bits per digit
    logic [IBW-1:0]  mag_b;
    logic            neg;
    logic [PW-1:0]   acc;
    logic [KW-1:0]   k;

    logic [IAW-1:0]  abs_a;
    logic [IBW-1:0]  abs_b;
    logic [IBW+1:0]  pp;
    logic [PW-1:0]   pp_sh;

    // The most negative input maps to 2^(W-1). That value still fits
    // unsigned in W bits, so no extra bit is needed here.
    assign abs_a = i_a[IAW-1] ? (~i_a + 1'b1) : i_a;
    assign abs_b = i_b[IBW-1] ? (~i_b + 1'b1) : i_b;

    // The digit is at most 3, so the product fits exactly in IBW+2 bits.
    assign pp    = {{IBW{1'b0}}, a_sh[1:0]} * {2'b00, mag_b};
    assign pp_sh = {{(PW-IBW-2){1'b0}}, pp} << {k, 1'b0};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            k      <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_p    <= '0;
        end else if (i_ce) begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        a_sh   <= abs_a;
                        mag_b  <= abs_b;
                        neg    <= i_a[IAW-1] ^ i_b[IBW-1];
                        acc    <= '0;
                        k      <= '0;
                        o_busy <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc  <= acc + pp_sh;
                    a_sh <= a_sh >> 2;
                    k    <= k + 1'b1;
                    if (k == K_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    o_p    <= neg ? -acc : acc;
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seqmpy_accum.sv
module tb_seqmpy_accum;
    logic        i_clk;
    logic        i_reset_n;
    logic        i_ce;
    logic        i_start;
    logic [7:0]  i_a;
    logic [7:0]  i_b;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_p;

    int n_chk  = 0;
    int n_pass = 0;
    int last_p = 0;
    logic prev_done;

    seqmpy_accum #(.IAW(8), .IBW(8)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_start   (i_start),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_p       (o_p)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // o_done must never be high on two consecutive enabled edges.
    always @(posedge i_clk) begin
        if (!i_reset_n) begin
            prev_done <= 1'b0;
        end else if (i_ce) begin
            if (o_done) check_val("done_twice", prev_done, 0);
            prev_done <= o_done;
        end
    end

    // Issue one product and wait for o_done. The loop counts every edge,
    // including disabled ones. i_ce is pulled low for stall_len edges,
    // starting stall_at edges after the accept.
    task automatic run_op(input logic signed [7:0] a, input logic signed [7:0] b,
                          input int stall_at, input int stall_len,
                          input bit poke, input bit full);
        int  exp;
        int  lat;
        bit  timeout;
        exp = int'(a) * int'(b);
        i_a = a;
        i_b = b;
        i_ce = 1'b1;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_a = 8'($urandom);
        i_b = 8'($urandom);
        if (full) check_val("busy_rise", o_busy, 1);
        lat = 0;
        timeout = 1'b0;
        forever begin
            i_ce = !(lat >= stall_at && lat < stall_at + stall_len);
            if (poke) begin
                i_start = lat[0];
                i_a = 8'd1;
                i_b = 8'd1;
            end
            @(posedge i_clk); #1;
            lat++;
            if (o_done) break;
            if (lat >= 40) begin
                timeout = 1'b1;
                break;
            end
            if (full) begin
                check_val("busy_run", o_busy, 1);
                check_val("p_hold", $signed(o_p), last_p);
            end
        end
        i_ce = 1'b1;
        i_start = 1'b0;
        if (timeout) check_val("done_timeout", 0, 1);
        check_val("latency", lat, 5 + stall_len);
        check_val("product", $signed(o_p), exp);
        if (full) check_val("busy_fall", o_busy, 0);
        last_p = exp;
    endtask

    initial begin
        int done_seen;
        i_reset_n = 1'b0;
        i_ce = 1'b1;
        i_start = 1'b0;
        i_a = '0;
        i_b = '0;
        #1;
        check_val("rst_busy", o_busy, 0);
        check_val("rst_done", o_done, 0);
        check_val("rst_p", $signed(o_p), 0);
        #11 i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        // Basic: 3*5. Then o_done must survive a disabled edge and clear on the next enabled one.
        run_op(8'sd3, 8'sd5, 99, 0, 1'b0, 1'b1);
        i_ce = 1'b0;
        @(posedge i_clk); #1;
        check_val("done_hold_ce", o_done, 1);
        i_ce = 1'b1;
        @(posedge i_clk); #1;
        check_val("done_fall", o_done, 0);
        check_val("p_after", $signed(o_p), 15);

        // Sign corners.
        run_op(-8'sd128, -8'sd128, 99, 0, 1'b0, 1'b1);
        run_op(-8'sd128, 8'sd127, 99, 0, 1'b0, 1'b1);
        run_op(8'sd127, -8'sd1, 99, 0, 1'b0, 1'b1);
        run_op(8'sd0, -8'sd77, 99, 0, 1'b0, 1'b1);

        // Back-to-back: the second start goes in during the o_done cycle.
        run_op(8'sd7, 8'sd9, 99, 0, 1'b0, 1'b1);
        run_op(-8'sd2, 8'sd100, 99, 0, 1'b0, 1'b1);

        // Starts poked during RUN are ignored.
        run_op(8'sd5, -8'sd6, 99, 0, 1'b1, 1'b1);

        // Three disabled cycles mid-RUN.
        run_op(8'sd12, -8'sd11, 2, 3, 1'b0, 1'b1);

        // Asynchronous reset mid-operation.
        i_a = 8'sd100;
        i_b = 8'sd100;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        check_val("busy_pre_rst", o_busy, 1);
        #2 i_reset_n = 1'b0;
        #1;
        check_val("arst_busy", o_busy, 0);
        check_val("arst_done", o_done, 0);
        check_val("arst_p", $signed(o_p), 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge i_clk); #1;
            if (o_done) done_seen++;
        end
        check_val("no_done_after_rst", done_seen, 0);
        last_p = 0;
        run_op(8'sd2, 8'sd3, 99, 0, 1'b0, 1'b1);

        // Random signed pairs.
        for (int i = 0; i < 10000; i++) begin
            run_op(8'($urandom), 8'($urandom), 99, 0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
